jtag_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller that sequences the JTAG serial datapath: a 16-state TMS-driven FSM, the instruction register, and the built-in BYPASS and IDCODE data registers. It produces the shift/capture/update strobes and the selected instruction consumed by user data registers. Its internal IR/DR serial outputs feed the TDO select stage, and it owns the falling-edge TDO retiming. It sits directly behind the chip's TCK/TMS/TDI/TDO/TRST_N pins.

---
 rtl/jtag_tap_ctrl.sv | 154 +++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state TMS FSM, instruction register, BYPASS/IDCODE DRs, falling-edge TDO.
// Optional macro JTAG_TAP_IDCODE_EN builds the IDCODE register; without it the IDCODE opcode selects BYPASS.
module jtag_tap_ctrl #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 4'b0001,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                dr_tdo_ext,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                test_logic_reset,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                capture_ir,
  output logic                shift_ir,
  output logic                update_ir
);

  // state     | meaning
  // TLR       | test logic reset, instruction forced to default
  // RTI       | run-test/idle
  // SEL_DR/IR | branch select toward DR or IR column
  // CAP_*     | parallel load of the selected register
  // SHIFT_*   | serial shift tdi -> register -> tdo
  // EXIT1/2_* | leave shift, toward pause or update
  // PAUSE_*   | shift registers hold
  // UPD_*     | update; leaving UPD_IR latches the new instruction
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } state_t;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_OP = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RESET_OP = '1;
`endif

  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("IR_WIDTH must be at least 2");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
    $error("IDCODE_VALUE bit 0 must be 1");
  end

  state_t              state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_reg;
  logic                bypass_reg;
  logic                sel_bypass;
  logic                dr_tdo;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:      state <= tms ? TLR      : RTI;
        RTI:      state <= tms ? SEL_DR   : RTI;
        SEL_DR:   state <= tms ? SEL_IR   : CAP_DR;
        CAP_DR:   state <= tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state <= tms ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state <= tms ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state <= tms ? SEL_DR   : RTI;
        SEL_IR:   state <= tms ? TLR      : CAP_IR;
        CAP_IR:   state <= tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state <= tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state <= tms ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state <= tms ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state <= tms ? SEL_DR   : RTI;
        default:  state <= TLR;
      endcase
    end
  end

  assign test_logic_reset = (state == TLR);
  assign capture_dr       = (state == CAP_DR);
  assign shift_dr         = (state == SHIFT_DR);
  assign update_dr        = (state == UPD_DR);
  assign capture_ir       = (state == CAP_IR);
  assign shift_ir         = (state == SHIFT_IR);
  assign update_ir        = (state == UPD_IR);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_shift <= '0;
      ir_reg   <= RESET_OP;
    end else begin
      if (capture_ir)
        ir_shift <= IR_CAPTURE;
      else if (shift_ir)
        ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      if (test_logic_reset)
        ir_reg <= RESET_OP;
      else if (update_ir)
        ir_reg <= ir_shift;
    end
  end

  // Override keeps the default instruction visible from the same edge that enters TLR.
  assign ir_out = test_logic_reset ? RESET_OP : ir_reg;

`ifdef JTAG_TAP_IDCODE_EN
  logic        sel_idcode;
  logic [31:0] idcode_reg;

  assign sel_bypass = &ir_out;
  assign sel_idcode = (ir_out == IDCODE_OP);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)
      idcode_reg <= IDCODE_VALUE;
    else if (sel_idcode && capture_dr)
      idcode_reg <= IDCODE_VALUE;
    else if (sel_idcode && shift_dr)
      idcode_reg <= {tdi, idcode_reg[31:1]};
  end

  assign dr_tdo = sel_bypass ? bypass_reg : (sel_idcode ? idcode_reg[0] : dr_tdo_ext);
`else
  assign sel_bypass = (&ir_out) || (ir_out == IDCODE_OP);
  assign dr_tdo     = sel_bypass ? bypass_reg : dr_tdo_ext;
`endif

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)
      bypass_reg <= 1'b0;
    else if (sel_bypass && capture_dr)
      bypass_reg <= 1'b0;
    else if (sel_bypass && shift_dr)
      bypass_reg <= tdi;
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= shift_ir | shift_dr;
      tdo    <= shift_ir ? ir_shift[0] : (shift_dr ? dr_tdo : 1'b0);
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: table-driven TMS/TDI vectors, expected outputs queued at drive time, compared after the falling edge.
module tb_jtag_tap_ctrl;

  localparam int S_TLR = 0,  S_RTI = 1,  S_SDS = 2,  S_CDR = 3,  S_SDR = 4,  S_E1D = 5,  S_PDR = 6,  S_E2D = 7;
  localparam int S_UDR = 8,  S_SIS = 9,  S_CIR = 10, S_SIR = 11, S_E1I = 12, S_PIR = 13, S_E2I = 14, S_UIR = 15;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] D_OP = 4'b0001;
  localparam logic       ID_FIRST = 1'b1;
`else
  localparam logic [3:0] D_OP = 4'b1111;
  localparam logic       ID_FIRST = 1'b0;
`endif

  logic       tck = 1'b0;
  logic       trst_n, tms, tdi, dr_tdo_ext;
  logic       tdo, tdo_en, test_logic_reset;
  logic       capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
  logic [3:0] ir_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       ext;
    int         st;
    logic       tdo;
    logic [3:0] ir;
  } vec_t;

  vec_t        vq[$];
  logic [12:0] exp_q[$];

  jtag_tap_ctrl dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .dr_tdo_ext(dr_tdo_ext),
    .tdo(tdo), .tdo_en(tdo_en), .ir_out(ir_out), .test_logic_reset(test_logic_reset),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir)
  );

  always #5 tck = ~tck;

  // Bundle: {tlr, cap_dr, shift_dr, upd_dr, cap_ir, shift_ir, upd_ir, tdo_en, tdo, ir_out}
  function automatic logic [12:0] expect_bits(int st, logic t, logic [3:0] ir);
    logic [6:0] s;
    s = '0;
    case (st)
      S_TLR: s[6] = 1'b1;
      S_CDR: s[5] = 1'b1;
      S_SDR: s[4] = 1'b1;
      S_UDR: s[3] = 1'b1;
      S_CIR: s[2] = 1'b1;
      S_SIR: s[1] = 1'b1;
      S_UIR: s[0] = 1'b1;
      default: ;
    endcase
    return {s, s[4] | s[1], t, ir};
  endfunction

  function automatic logic [12:0] actual_bits();
    return {test_logic_reset, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir,
            tdo_en, tdo, ir_out};
  endfunction

  task automatic compare(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = actual_bits();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic void add(logic m, logic d, logic e, int st, logic t, logic [3:0] ir);
    vec_t v;
    v.tms = m; v.tdi = d; v.ext = e; v.st = st; v.tdo = t; v.ir = ir;
    vq.push_back(v);
  endfunction

  task automatic step(input vec_t v, input string name);
    tms = v.tms;
    tdi = v.tdi;
    dr_tdo_ext = v.ext;
    exp_q.push_back(expect_bits(v.st, v.tdo, v.ir));
    @(posedge tck);
    @(negedge tck);
    #1;
    compare(name, exp_q.pop_front());
  endtask

  task automatic run_table(input string tag);
    foreach (vq[i]) step(vq[i], $sformatf("%s[%0d]", tag, i));
    vq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pat;
    logic [31:0] idc;
    logic        eb;
    trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; dr_tdo_ext = 1'b0;
    #2;
    compare("async_reset_no_tck", expect_bits(S_TLR, 1'b0, D_OP));
    #1 trst_n = 1'b1;

    // IR load of user opcode 0010, external DR shift with pause, then BYPASS load and shift
    add(0,0,0,S_RTI,0,D_OP);   add(1,0,0,S_SDS,0,D_OP);   add(1,0,0,S_SIS,0,D_OP);
    add(0,0,0,S_CIR,0,D_OP);   add(0,0,0,S_SIR,1,D_OP);   add(0,0,0,S_SIR,0,D_OP);
    add(0,1,0,S_SIR,0,D_OP);   add(0,0,0,S_SIR,0,D_OP);   add(1,0,0,S_E1I,0,D_OP);
    add(1,0,0,S_UIR,0,D_OP);   add(0,0,0,S_RTI,0,4'b0010); add(1,0,0,S_SDS,0,4'b0010);
    add(0,0,0,S_CDR,0,4'b0010); add(0,0,1,S_SDR,1,4'b0010); add(0,0,0,S_SDR,0,4'b0010);
    add(0,0,1,S_SDR,1,4'b0010); add(1,0,1,S_E1D,0,4'b0010); add(0,0,1,S_PDR,0,4'b0010);
    add(0,0,0,S_PDR,0,4'b0010); add(1,0,0,S_E2D,0,4'b0010); add(0,0,1,S_SDR,1,4'b0010);
    add(1,0,1,S_E1D,0,4'b0010); add(1,0,0,S_UDR,0,4'b0010); add(1,0,0,S_SDS,0,4'b0010);
    add(1,0,0,S_SIS,0,4'b0010); add(0,0,0,S_CIR,0,4'b0010); add(0,0,0,S_SIR,1,4'b0010);
    add(0,1,0,S_SIR,0,4'b0010); add(0,1,0,S_SIR,0,4'b0010); add(0,1,0,S_SIR,0,4'b0010);
    add(1,1,0,S_E1I,0,4'b0010); add(1,0,0,S_UIR,0,4'b0010); add(0,0,0,S_RTI,0,4'b1111);
    add(1,0,0,S_SDS,0,4'b1111); add(0,0,0,S_CDR,0,4'b1111); add(0,0,0,S_SDR,0,4'b1111);
    add(0,1,0,S_SDR,1,4'b1111); add(0,0,0,S_SDR,0,4'b1111); add(0,1,0,S_SDR,1,4'b1111);
    add(0,1,0,S_SDR,1,4'b1111); add(1,0,0,S_E1D,0,4'b1111); add(0,0,0,S_PDR,0,4'b1111);
    add(1,0,0,S_E2D,0,4'b1111); add(1,0,0,S_UDR,0,4'b1111); add(0,0,0,S_RTI,0,4'b1111);
    // IR load of the IDCODE opcode, then into CAP_DR
    add(1,0,0,S_SDS,0,4'b1111); add(1,0,0,S_SIS,0,4'b1111); add(0,0,0,S_CIR,0,4'b1111);
    add(0,0,0,S_SIR,1,4'b1111); add(0,1,0,S_SIR,0,4'b1111); add(0,0,0,S_SIR,0,4'b1111);
    add(0,0,0,S_SIR,0,4'b1111); add(1,0,0,S_E1I,0,4'b1111); add(1,0,0,S_UIR,0,4'b1111);
    add(0,0,0,S_RTI,0,4'b0001); add(1,0,0,S_SDS,0,4'b0001); add(0,0,0,S_CDR,0,4'b0001);
    run_table("main");

    // 32-bit DR read under the IDCODE opcode; tdi pattern reappears when BYPASS is selected
    pat = 32'hA5C3_0F96;
    idc = 32'h1000_0001;
    for (int k = 0; k < 32; k++) begin
`ifdef JTAG_TAP_IDCODE_EN
      eb = idc[k];
`else
      eb = (k == 0) ? 1'b0 : pat[k];
`endif
      add(0, pat[k], 0, S_SDR, eb, 4'b0001);
    end
    run_table("idcode_read");

    // Reset asserted during the second SHIFT_IR bit
    add(1,0,0,S_E1D,0,4'b0001); add(1,0,0,S_UDR,0,4'b0001); add(1,0,0,S_SDS,0,4'b0001);
    add(1,0,0,S_SIS,0,4'b0001); add(0,0,0,S_CIR,0,4'b0001); add(0,0,0,S_SIR,1,4'b0001);
    add(0,1,0,S_SIR,0,4'b0001);
    run_table("pre_reset");
    trst_n = 1'b0;
    #1;
    compare("reset_mid_shift", expect_bits(S_TLR, 1'b0, D_OP));
    #1 trst_n = 1'b1;

    // TMS escape from SHIFT_DR, then from PAUSE_IR after staging opcode 0010
    add(0,0,0,S_RTI,0,D_OP);   add(1,0,0,S_SDS,0,D_OP);   add(0,0,0,S_CDR,0,D_OP);
    add(0,0,0,S_SDR,ID_FIRST,D_OP); add(0,0,0,S_SDR,0,D_OP);
    add(1,0,0,S_E1D,0,D_OP);   add(1,0,0,S_UDR,0,D_OP);   add(1,0,0,S_SDS,0,D_OP);
    add(1,0,0,S_SIS,0,D_OP);   add(1,0,0,S_TLR,0,D_OP);
    add(0,0,0,S_RTI,0,D_OP);   add(1,0,0,S_SDS,0,D_OP);   add(1,0,0,S_SIS,0,D_OP);
    add(0,0,0,S_CIR,0,D_OP);   add(0,0,0,S_SIR,1,D_OP);   add(0,0,0,S_SIR,0,D_OP);
    add(0,1,0,S_SIR,0,D_OP);   add(0,0,0,S_SIR,0,D_OP);   add(1,0,0,S_E1I,0,D_OP);
    add(0,0,0,S_PIR,0,D_OP);   add(1,0,0,S_E2I,0,D_OP);   add(1,0,0,S_UIR,0,D_OP);
    add(1,0,0,S_SDS,0,4'b0010); add(1,0,0,S_SIS,0,4'b0010); add(1,0,0,S_TLR,0,D_OP);
    run_table("escape");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
